apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
APB initiator that turns single transfer requests from an internal command port into APB SETUP/ACCESS cycles on PCLK. It sits between a local controller (CPU bridge, DMA or test sequencer) and APB slaves such as our 256-word register/memory slave at 0x4000_00xx. It returns read data and slave error status on a response port, and enforces a bounded wait so a hung slave cannot stall the requester.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort; 0 disables timeout

Ports:
PCLK  in  1  APB clock; all logic on rising edge
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  request valid
cmd_ready  out  1  request accepted when cmd_valid && cmd_ready at PCLK edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
rsp_err  out  2  00 ok, 01 slave write error, 10 slave read error, 11 timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  2  slave error code, sampled with PREADY

Behaviour:
- One clock (PCLK); reset is asynchronous and active-high (PRESET).
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=00, state=IDLE, wait counter=0.
- All APB outputs and rsp_* outputs are registered. cmd_ready = (state==IDLE) && !PRESET (combinational).
- FSM states:
  - IDLE: on cmd_valid, latch write/addr/wdata onto PWRITE/PADDR/PWDATA, set PSEL=1, and go to SETUP.
  - SETUP: one cycle with PSEL=1, PENABLE=0. Then set PENABLE=1, clear the wait counter, and go to ACCESS.
  - ACCESS: while PREADY=0, stay and increment the counter.
    - On PREADY=1: PSEL=0, PENABLE=0. Set rsp_rdata = PWRITE ? 0 : PRDATA and rsp_err = PSLVERR. Set rsp_valid=1 and go to RESP.
    - Timeout (TIMEOUT!=0 and counter==TIMEOUT-1 and PREADY=0): PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=11, rsp_valid=1, go to RESP.
  - RESP: hold rsp_* stable. On rsp_ready, set rsp_valid=0 and go to IDLE.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS. They hold their last values while idle and do not toggle.
- PREADY and PSLVERR are ignored outside ACCESS.
- PREADY=1 in the same cycle the timeout expires: PREADY wins and the transfer completes normally.
- Latency:
  - Zero-wait slave: acceptance edge to rsp_valid = 3 cycles.
  - Registered-PREADY slave (ready one cycle after PENABLE): 4 cycles.
  - Back-to-back: the next command is accepted on the edge after the rsp_valid && rsp_ready handshake. Minimum 4 cycles per transfer with a zero-wait slave.
- Addresses pass through unmodified; no alignment or decode checks (decode errors come from the slave via PSLVERR).
- Reset mid-transfer: everything returns to reset values immediately. The in-flight transfer is dropped with no response.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - error codes APB_OK=2'b00, APB_WR_ERR=2'b01, APB_RD_ERR=2'b10, APB_TIMEOUT=2'b11
  - default widths
- One sub-module, apb_wait_timer:
  - parameterised by TIMEOUT, counter width $clog2(TIMEOUT+1)
  - inputs: clear, count enable
  - output: expired pulse
  - TIMEOUT=0 ties expired low.

Test Plan:
- Write then read against the 256-word slave model (registered PREADY): write 0x4000_0010 data 0xDEAD_BEEF, then read 0x4000_0010 -> write rsp_err=00, rsp_rdata=0; read rsp_rdata=0xDEAD_BEEF, rsp_err=00; each rsp_valid exactly 4 cycles after acceptance; PSEL high 3 cycles, PENABLE high 2.
- Out-of-range access: write 0x5000_0000, then read 0x5000_0004 -> rsp_err=01 then 10; read rsp_rdata=0.
- Timeout: TIMEOUT=4, slave PREADY tied 0 -> ACCESS lasts 4 cycles; PSEL/PENABLE drop; rsp_err=11, rsp_rdata=0. Repeat with PREADY=1 exactly on the 4th ACCESS cycle -> normal completion, rsp_err=00.
- Response backpressure: rsp_ready held 0 for 5 cycles after a read -> rsp_valid and rsp_rdata stable throughout, cmd_ready=0, no PSEL activity; completes on rsp_ready=1.
- Back-to-back: cmd_valid held high for 3 writes to 0x4000_0000/01/02, zero-wait slave, rsp_ready=1 -> each transfer 4 cycles, correct PADDR sequence, no SETUP without a preceding idle/handshake.
- Reset mid-ACCESS: assert PRESET during PENABLE=1 -> PSEL/PENABLE/rsp_valid go 0 asynchronously; after release, cmd_ready=1 and no stale response.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM states, response error codes, default widths.
package apb_pkg;

    localparam int unsigned APB_ADDR_W  = 32;
    localparam int unsigned APB_DATA_W  = 32;
    localparam int unsigned APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [1:0] APB_OK      = 2'b00;
    localparam logic [1:0] APB_WR_ERR  = 2'b01;
    localparam logic [1:0] APB_RD_ERR  = 2'b10;
    localparam logic [1:0] APB_TIMEOUT_ERR = 2'b11;

endpackage : apb_pkg

// File: rtl/apb_wait_timer.sv
// Bounded wait counter for the APB ACCESS phase.
// Ports: clk, rst (async active-high), clear (zero the counter),
//        count_en (one more cycle without PREADY),
//        expired_c (combinational: the current ACCESS cycle is the last allowed one).
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired_c
);

    if (TIMEOUT == 0) begin : g_no_timeout
        assign expired_c = 1'b0;
    end else begin : g_timeout
        localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Next count: clear wins over counting.
        always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
                cnt_d = '0;
            end else if (count_en) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Counter starts at 0 in the first ACCESS cycle, so TIMEOUT-1 marks the last one.
        assign expired_c = count_en && (cnt_q == CNT_W'(TIMEOUT - 1));
    end

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// APB initiator: converts single command-port requests into SETUP/ACCESS
// cycles and returns read data / error status on a held response port.
// Ports: PCLK, PRESET (async active-high);
//        cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata (request);
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err (response);
//        PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR (APB).
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic [1:0]        PSLVERR
);

    apb_state_e        state_q,     state_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q,   rsp_err_d;

    logic timer_clear;
    logic timer_en;
    logic timer_expired_c;

    // Timer control comes straight from state so the expiry path has no loop through the FSM.
    assign timer_clear = (state_q == SETUP);
    assign timer_en    = (state_q == ACCESS) && !PREADY;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (PCLK),
        .rst       (PRESET),
        .clear     (timer_clear),
        .count_en  (timer_en),
        .expired_c (timer_expired_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY has priority over an expiry in the same cycle.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timer_expired_c) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = APB_TIMEOUT_ERR;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= APB_OK;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !PRESET;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 256-word APB slave model at 0x4000_00xx.
// Latency is counted as edges from the acceptance edge to the edge at which
// the requester first samples rsp_valid high.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic [1:0]  PSLVERR;

    int total = 0;
    int bad   = 0;

    // 0 registered PREADY, 1 zero-wait, 2 PREADY stuck low, 3 ready on 4th ACCESS cycle
    int          slave_mode = 0;
    int          acc_cnt    = 0;
    logic [31:0] mem [256];
    logic        in_range;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Slave model
    assign in_range = (PADDR[31:8] == 24'h400000);

    always_comb begin
        case (slave_mode)
            0:       PREADY = PSEL && PENABLE && (acc_cnt >= 1);
            1:       PREADY = PSEL && PENABLE;
            2:       PREADY = 1'b0;
            default: PREADY = PSEL && PENABLE && (acc_cnt == 3);
        endcase
        PRDATA  = in_range ? mem[PADDR[7:0]] : 32'h0;
        PSLVERR = in_range ? 2'b00 : (PWRITE ? 2'b01 : 2'b10);
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else if (!PENABLE)              acc_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE && in_range) mem[PADDR[7:0]] <= PWDATA;
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with rsp_ready high; reports response and phase counts.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic [1:0] err,
                           output int lat, output int nsel, output int nen);
        int  k;
        bit  done;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL xfer_cmd_ready got=%b exp=1", cmd_ready); end
        tick;
        cmd_valid = 1'b0;
        k = 0; nsel = 0; nen = 0; done = 1'b0;
        while (k < 50 && !done) begin
            if (rsp_valid === 1'b1) done = 1'b1;
            else begin
                if (PSEL === 1'b1) nsel++;
                if (PENABLE === 1'b1) nen++;
                tick; k++;
            end
        end
        lat = k + 1; rdata = rsp_rdata; err = rsp_err;
        total++;
        if (!done) begin bad++; $display("FAIL xfer_rsp_timeout addr=%h no rsp_valid in 50 cycles", addr); end
        tick;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL xfer_rsp_drop got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_reset;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        tick;
        total++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, cmd_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000", {PSEL, PENABLE, PWRITE, rsp_valid, cmd_ready});
        end
        total++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin
            bad++; $display("FAIL reset_bus paddr=%h pwdata=%h exp=0", PADDR, PWDATA);
        end
        total++;
        if (rsp_rdata !== 32'h0 || rsp_err !== 2'b00) begin
            bad++; $display("FAIL reset_rsp rdata=%h err=%b exp=0/00", rsp_rdata, rsp_err);
        end
        tick;
        PRESET = 1'b0;
        tick;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic [1:0] er; int lat, ns, ne;
        slave_mode = 0;
        do_xfer(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, rd, er, lat, ns, ne);
        total++; if (er !== 2'b00) begin bad++; $display("FAIL wr_err got=%b exp=00", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rd); end
        total++; if (lat != 4) begin bad++; $display("FAIL wr_latency got=%0d exp=4", lat); end
        total++; if (ns != 3 || ne != 2) begin bad++; $display("FAIL wr_phases psel=%0d pen=%0d exp=3/2", ns, ne); end
        do_xfer(1'b0, 32'h4000_0010, 32'h0, rd, er, lat, ns, ne);
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", rd); end
        total++; if (er !== 2'b00) begin bad++; $display("FAIL rd_err got=%b exp=00", er); end
        total++; if (lat != 4) begin bad++; $display("FAIL rd_latency got=%0d exp=4", lat); end
        total++; if (ns != 3 || ne != 2) begin bad++; $display("FAIL rd_phases psel=%0d pen=%0d exp=3/2", ns, ne); end
        // PRDATA shows DEADBEEF during this write; response data must still be zero.
        do_xfer(1'b1, 32'h4000_0010, 32'h1234_5678, rd, er, lat, ns, ne);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL wr2_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic [1:0] er; int lat, ns, ne;
        slave_mode = 0;
        do_xfer(1'b1, 32'h5000_0000, 32'hCAFE_F00D, rd, er, lat, ns, ne);
        total++; if (er !== 2'b01) begin bad++; $display("FAIL oor_wr_err got=%b exp=01", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_wr_rdata got=%h exp=0", rd); end
        do_xfer(1'b0, 32'h5000_0004, 32'h0, rd, er, lat, ns, ne);
        total++; if (er !== 2'b10) begin bad++; $display("FAIL oor_rd_err got=%b exp=10", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rd_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd; logic [1:0] er; int lat, ns, ne;
        slave_mode = 2;
        do_xfer(1'b0, 32'h4000_0010, 32'h0, rd, er, lat, ns, ne);
        total++; if (er !== 2'b11) begin bad++; $display("FAIL to_err got=%b exp=11", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", rd); end
        total++; if (ne != 4 || ns != 5) begin bad++; $display("FAIL to_phases psel=%0d pen=%0d exp=5/4", ns, ne); end
        total++; if (lat != 6) begin bad++; $display("FAIL to_latency got=%0d exp=6", lat); end
        slave_mode = 3;
        do_xfer(1'b0, 32'h4000_0010, 32'h0, rd, er, lat, ns, ne);
        total++; if (er !== 2'b00) begin bad++; $display("FAIL late_ready_err got=%b exp=00", er); end
        total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL late_ready_rdata got=%h exp=12345678", rd); end
        total++; if (ne != 4) begin bad++; $display("FAIL late_ready_pen got=%0d exp=4", ne); end
        slave_mode = 0;
    endtask

    task automatic test_backpressure;
        int k;
        slave_mode = 0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010; cmd_wdata = 32'h0;
        tick;
        // A second pending command must not start while the response is held.
        cmd_write = 1'b1; cmd_addr = 32'h4000_0020; cmd_wdata = 32'h5555_AAAA;
        k = 0;
        while (k < 50 && rsp_valid !== 1'b1) begin tick; k++; end
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_timeout no rsp_valid in 50 cycles"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin
                bad++; $display("FAIL bp_hold cyc=%0d valid=%b rdata=%h exp=1/12345678", i, rsp_valid, rsp_rdata);
            end
            total++;
            if (cmd_ready !== 1'b0 || PSEL !== 1'b0 || PADDR !== 32'h4000_0010) begin
                bad++; $display("FAIL bp_idle_bus cyc=%0d ready=%b psel=%b paddr=%h exp=0/0/40000010", i, cmd_ready, PSEL, PADDR);
            end
            tick;
        end
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        tick;
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        int          n, ns;
        int          acc [3];
        logic [31:0] setup_addr [4];
        logic [31:0] rd; logic [1:0] er; int lat, nsel, nen;
        bit          accepted;
        slave_mode = 1; rsp_ready = 1'b1;
        n = 0; ns = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0000; cmd_wdata = 32'hB2B0_0000;
        for (int c = 0; c < 16; c++) begin
            accepted = 1'b0;
            if (cmd_valid && cmd_ready === 1'b1) begin acc[n] = c; n++; accepted = 1'b1; end
            if (PSEL === 1'b1 && PENABLE === 1'b0 && ns < 4) begin setup_addr[ns] = PADDR; ns++; end
            tick;
            if (accepted) begin
                if (n == 3) cmd_valid = 1'b0;
                else begin cmd_addr = 32'h4000_0000 + 32'(n); cmd_wdata = 32'hB2B0_0000 + 32'(n); end
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
        total++; if (n == 3 && (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4)) begin
            bad++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", acc[1] - acc[0], acc[2] - acc[1]);
        end
        total++; if (ns != 3) begin bad++; $display("FAIL b2b_setups got=%0d exp=3", ns); end
        total++; if (ns == 3 && (setup_addr[0] !== 32'h4000_0000 || setup_addr[1] !== 32'h4000_0001 ||
                                 setup_addr[2] !== 32'h4000_0002)) begin
            bad++; $display("FAIL b2b_paddr got=%h,%h,%h exp=40000000,40000001,40000002",
                            setup_addr[0], setup_addr[1], setup_addr[2]);
        end
        do_xfer(1'b0, 32'h4000_0001, 32'h0, rd, er, lat, nsel, nen);
        total++; if (rd !== 32'hB2B0_0001) begin bad++; $display("FAIL zw_rdata got=%h exp=b2b00001", rd); end
        total++; if (lat != 3) begin bad++; $display("FAIL zw_latency got=%0d exp=3", lat); end
        total++; if (nsel != 2 || nen != 1) begin bad++; $display("FAIL zw_phases psel=%0d pen=%0d exp=2/1", nsel, nen); end
        slave_mode = 0;
    endtask

    task automatic test_reset_mid_access;
        int k;
        slave_mode = 0; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010;
        tick;
        cmd_valid = 1'b0;
        k = 0;
        while (k < 20 && PENABLE !== 1'b1) begin tick; k++; end
        total++;
        if (PENABLE !== 1'b1) begin bad++; $display("FAIL rst_mid_no_access PENABLE never rose"); end
        #2 PRESET = 1'b1;
        #1;
        total++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0) begin
            bad++; $display("FAIL rst_mid_async got=%b exp=0000", {PSEL, PENABLE, rsp_valid, cmd_ready});
        end
        tick;
        PRESET = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", cmd_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
                bad++; $display("FAIL rst_mid_stale cyc=%0d valid=%b psel=%b exp=0/0", i, rsp_valid, PSEL);
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_out_of_range;
        test_timeout;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_access;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish by 100000");
        $fatal(1);
    end

endmodule : tb_apb_master
